// File: rtl/rf_issue_stage_pkg.sv
// Shared sizing defaults for the CLAP register-read/issue stage.
package rf_issue_stage_pkg;

  localparam int unsigned DefNlane = 2;
  localparam int unsigned DefNwb   = 2;
  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNreg  = 32;
  localparam int unsigned PayloadW = 64;

endpackage

// File: rtl/rf_issue_stage_scoreboard.sv
// Busy-bit scoreboard for long-latency results; exposes busy with same-cycle release applied.
module rf_scoreboard
  import rf_issue_stage_pkg::*;
#(
  parameter int unsigned NLANE = DefNlane,
  parameter int unsigned NWB   = DefNwb,
  parameter int unsigned NREG  = DefNreg,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NLANE-1:0]    set_en,
  input  logic [NLANE*AW-1:0] set_addr,
  input  logic [NWB-1:0]      clr_en,
  input  logic [NWB*AW-1:0]   clr_addr,
  output logic [NREG-1:0]     busy_eff
);

  logic [NREG-1:0] busy_q, busy_d, clr_hit;

  always_comb begin
    clr_hit = '0;
    for (int unsigned p = 0; p < NWB; p++) begin
      if (clr_en[p]) clr_hit[clr_addr[p*AW +: AW]] = 1'b1;
    end
  end

  assign busy_eff = busy_q & ~clr_hit;

  // Sets are applied after clears so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q & ~clr_hit;
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (set_en[i]) busy_d[set_addr[i*AW +: AW]] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/rf_issue_stage.sv
// Register-read/issue stage: RF with write-back bypass, scoreboard hold, in-order issue
// into a one-deep output register.
module rf_issue_stage
  import rf_issue_stage_pkg::*;
#(
  parameter int unsigned NLANE = DefNlane,
  parameter int unsigned NWB   = DefNwb,
  parameter int unsigned XLEN  = DefXlen,
  parameter int unsigned NREG  = DefNreg,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NLANE-1:0]          in_valid,
  output logic [NLANE-1:0]          in_ready,
  input  logic [NLANE*AW-1:0]       in_rj,
  input  logic [NLANE*AW-1:0]       in_rk,
  input  logic [NLANE*AW-1:0]       in_rd,
  input  logic [NLANE-1:0]          in_rd_we,
  input  logic [NLANE-1:0]          in_long,
  input  logic [NLANE*PayloadW-1:0] in_payload,
  input  logic [NWB-1:0]            wb_en,
  input  logic [NWB*AW-1:0]         wb_addr,
  input  logic [NWB*XLEN-1:0]       wb_data,
  input  logic [NWB-1:0]            wb_long,
  output logic [NLANE-1:0]          out_valid,
  input  logic                      out_ready,
  output logic [NLANE*XLEN-1:0]     out_rj_data,
  output logic [NLANE*XLEN-1:0]     out_rk_data,
  output logic [NLANE*AW-1:0]       out_rd,
  output logic [NLANE-1:0]          out_rd_we,
  output logic [NLANE*PayloadW-1:0] out_payload
);

  logic [XLEN-1:0]           rf_q [NREG];
  logic [NREG-1:0]           busy_eff;
  logic [NLANE-1:0]          elig, set_en;
  logic                      prefix_ok, adv;
  logic [NLANE*XLEN-1:0]     rj_data, rk_data;

  logic [NLANE-1:0]          out_valid_q, out_rd_we_q;
  logic [NLANE*XLEN-1:0]     out_rj_q, out_rk_q;
  logic [NLANE*AW-1:0]       out_rd_q;
  logic [NLANE*PayloadW-1:0] out_payload_q;

  rf_scoreboard #(
    .NLANE(NLANE),
    .NWB  (NWB),
    .NREG (NREG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .set_en  (set_en),
    .set_addr(in_rd),
    .clr_en  (wb_en & wb_long),
    .clr_addr(wb_addr),
    .busy_eff(busy_eff)
  );

  // Operand read: x0, then highest matching write-back port, then the array.
  always_comb begin
    rj_data = '0;
    rk_data = '0;
    for (int unsigned l = 0; l < NLANE; l++) begin
      rj_data[l*XLEN +: XLEN] = rf_q[in_rj[l*AW +: AW]];
      rk_data[l*XLEN +: XLEN] = rf_q[in_rk[l*AW +: AW]];
      for (int unsigned p = 0; p < NWB; p++) begin
        if (wb_en[p] && wb_addr[p*AW +: AW] == in_rj[l*AW +: AW]) begin
          rj_data[l*XLEN +: XLEN] = wb_data[p*XLEN +: XLEN];
        end
        if (wb_en[p] && wb_addr[p*AW +: AW] == in_rk[l*AW +: AW]) begin
          rk_data[l*XLEN +: XLEN] = wb_data[p*XLEN +: XLEN];
        end
      end
      if (in_rj[l*AW +: AW] == '0) rj_data[l*XLEN +: XLEN] = '0;
      if (in_rk[l*AW +: AW] == '0) rk_data[l*XLEN +: XLEN] = '0;
    end
  end

  // In-order eligibility; only an older long-latency writer blocks a younger reader.
  always_comb begin
    elig      = '0;
    prefix_ok = 1'b1;
    for (int unsigned i = 0; i < NLANE; i++) begin
      elig[i] = prefix_ok && in_valid[i] &&
                !busy_eff[in_rj[i*AW +: AW]] && !busy_eff[in_rk[i*AW +: AW]];
      for (int unsigned j = 0; j < i; j++) begin
        if (in_rd_we[j] && in_long[j] && in_rd[j*AW +: AW] != '0 &&
            (in_rd[j*AW +: AW] == in_rj[i*AW +: AW] ||
             in_rd[j*AW +: AW] == in_rk[i*AW +: AW])) begin
          elig[i] = 1'b0;
        end
      end
      prefix_ok = elig[i];
    end
  end

  assign adv      = !(|out_valid_q) || out_ready;
  assign in_ready = (adv && !flush && !rst) ? elig : '0;
  assign set_en   = in_ready & in_rd_we & in_long;

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NWB; p++) begin
      if (wb_en[p] && wb_addr[p*AW +: AW] != '0) begin
        rf_q[wb_addr[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= '0;
      out_rj_q      <= '0;
      out_rk_q      <= '0;
      out_rd_q      <= '0;
      out_rd_we_q   <= '0;
      out_payload_q <= '0;
    end else if (flush) begin
      out_valid_q <= '0;
    end else if (adv) begin
      out_valid_q   <= in_ready;
      out_rj_q      <= rj_data;
      out_rk_q      <= rk_data;
      out_rd_q      <= in_rd;
      out_rd_we_q   <= in_rd_we;
      out_payload_q <= in_payload;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rj_data = out_rj_q;
  assign out_rk_data = out_rk_q;
  assign out_rd      = out_rd_q;
  assign out_rd_we   = out_rd_we_q;
  assign out_payload = out_payload_q;

endmodule
